uart_cmd_receiver: RTL and testbench
====================================

// Module: uart_cmd_receiver
// PURPOSE
//  Serial front end for the virtual-input path. Receives 8-bit commands from the host PC
//  on a UART line, validates them, and drives the 4-bit input index, the toggle strobe and
//  the LED echo consumed by the virtual button/switch decoder stage directly downstream.
//  The strobe is a stretched pulse because the downstream stage uses it as an edge.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency
//  BAUD          115_200     line rate
//  OVERSAMPLE    16          rx samples per bit; DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), DIV>=2
//  PULSE_CYCLES  8           clocks control is held high; also minimum low gap after it
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous reset, active low
//  rx         in   1  UART line, idle high, asynchronous to clk
//  number     out  4  index of input to toggle (to decoder number)
//  control    out  1  toggle strobe, high PULSE_CYCLES clocks (to decoder control)
//  value      out  1  LED echo bit from last accepted command (to decoder value)
//  cmd_err    out  1  1-clk pulse: well-framed byte with bad marker
//  frame_err  out  1  1-clk pulse: stop bit (or parity) failure
//  overrun    out  1  1-clk pulse: command dropped, holding slot full
// BEHAVIOUR
//  - Reset: number=0, control=0, value=0, all error pulses 0, FSM=IDLE, holding slot empty.
//    Reset mid-frame or mid-pulse aborts everything; control drops immediately (async).
//  - rx through 2-FF synchronizer; all sampling uses synchronized rx. Oversample tick every DIV clks.
//  - Format 8N1, LSB first. FSM: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> IDLE.
//  - IDLE: falling edge of rx starts tick counter. START: sample at tick OVERSAMPLE/2; if high,
//    glitch -> IDLE, nothing reported. DATA/STOP: sample each bit at mid-bit (every OVERSAMPLE ticks).
//  - STOP sample 0: frame_err pulse, byte dropped, FSM waits for rx high before IDLE.
//  - Command byte: [7:5]=CMD_MARKER 3'b101, [4]=value, [3:0]=index. Marker mismatch: cmd_err, drop.
//  - Accepted byte enters 1-entry holding slot in the clock after stop-bit sample.
//  - Issue: when slot full and issuer idle: cycle N number<=index, value<=bit4, slot freed;
//    cycle N+1..N+PULSE_CYCLES control=1; then >=PULSE_CYCLES clocks control=0 before next issue.
//    number/value stable from N until next issue (setup+hold around control edge).
//  - Byte accepted while slot full: overrun pulse, new byte dropped, slot keeps older one.
//  - Simultaneous slot-fill and slot-drain in one clock: new byte takes slot, no overrun.
//  - Pulse counter saturates; no wrap. Tick/bit counters reset on every start edge.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame is 8E1; PARITY state samples bit 9; even-parity mismatch ->
//    frame_err, byte dropped (STOP still sampled, no double pulse).
//  PARITY_CHECK_EN undefined: 8N1, no PARITY state, parity logic absent.
// STRUCTURE
//  Package uart_cmd_pkg: rx FSM state enum, CMD_MARKER, field positions (VALUE_BIT=4,
//    IDX_MSB=3), localparam helper for DIV.
//  Sub-module uart_rx_core: synchronizer, baud tick, deframing FSM, parity; outputs
//    byte[7:0], byte_valid, frame_err. Top holds marker check, holding slot, pulse issuer.
// TESTING (sim with CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 -> DIV=1 disallowed; use
//  CLK_HZ=3_200_000 -> DIV=2, PULSE_CYCLES=8)
//  1 send 0xA5 -> number=5, value=0 one clk after slot fill; control high exactly 8 clks after.
//  2 send 0xB3 after 1 -> number=3, value=1, control pulse 8 clks; no error pulses.
//  3 send 0x45 -> cmd_err 1-clk pulse; number/value/control unchanged.
//  4 send 0xA1 with stop=0, then hold rx high 2 bits, send 0xA2 -> frame_err once; number=2 pulse only.
//  5 rx low for 3 ticks then high -> no frame, no pulses; following 0xA7 received, number=7.
//  6 rst_n low mid-DATA of 0xAF then 0xA4 -> outputs 0 during reset; only number=4 issued.
//  (PARITY_CHECK_EN) 0xA5 with odd parity bit -> frame_err, no control.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
// Optional feature macro: PARITY_CHECK_EN (8E1 framing with even-parity check).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef PARITY_CHECK_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_SETUP,
    ISS_PULSE,
    ISS_GAP
  } iss_state_t;

  localparam logic [2:0] CMD_MARKER = 3'b101;
  localparam int         VALUE_BIT  = 4;
  localparam int         IDX_MSB    = 3;

  // Rounded clocks-per-oversample-tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART deframer: rx synchronizer, oversample tick, 8N1/8E1 FSM.
// Optional feature macro: PARITY_CHECK_EN.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = $clog2(DIV);
  localparam int TW  = $clog2(OVERSAMPLE);

  rx_state_t       state, state_nxt;
  logic            rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]   div_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            tick, sample, start_edge;
  logic            valid_nxt, ferr_nxt;
`ifdef PARITY_CHECK_EN
  logic            par_err;
`endif

  assign tick       = (div_cnt == DW'(DIV - 1));
  assign start_edge = (state == RX_IDLE) && rx_prev && !rx_sync;
  // Start bit is checked half a bit in; every later bit one full bit later.
  assign sample     = tick && ((state == RX_START) ? (tick_cnt == TW'(OVERSAMPLE / 2 - 1))
                                                   : (tick_cnt == TW'(OVERSAMPLE - 1)));
  assign rx_byte    = shift;

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE:  if (start_edge) state_nxt = RX_START;
      RX_START: if (sample) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (sample && bit_cnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
          state_nxt = RX_PARITY;
`else
          state_nxt = RX_STOP;
`endif
        end
`ifdef PARITY_CHECK_EN
      RX_PARITY: if (sample) state_nxt = RX_STOP;
`endif
      RX_STOP:
        if (sample) begin
          if (rx_sync) begin
            state_nxt = RX_IDLE;
`ifdef PARITY_CHECK_EN
            valid_nxt = !par_err;
            ferr_nxt  = par_err;
`else
            valid_nxt = 1'b1;
`endif
          end else begin
            state_nxt = RX_WAIT;
            ferr_nxt  = 1'b1;
          end
        end
      RX_WAIT:  if (rx_sync) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;
      if (start_edge) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
`ifdef PARITY_CHECK_EN
        par_err  <= 1'b0;
`endif
      end else if (tick) begin
        tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
      end
      if (state == RX_DATA && sample) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
`ifdef PARITY_CHECK_EN
      if (state == RX_PARITY && sample) par_err <= ^{shift, rx_sync};
`endif
    end
  end

endmodule

// File: rtl/uart_cmd_receiver.sv
// UART command front end: marker check, 1-entry holding slot, stretched toggle strobe.
// Optional feature macro: PARITY_CHECK_EN (forwarded to uart_rx_core).
module uart_cmd_receiver
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int OVERSAMPLE   = 16,
  parameter int PULSE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] number,
  output logic       control,
  output logic       value,
  output logic       cmd_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [7:0]  rx_byte;
  logic        byte_valid, marker_ok, accept, drain;
  logic        slot_full;
  logic [4:0]  slot_cmd;
  iss_state_t  iss_state, iss_nxt;
  logic [CW-1:0] pcnt;
  logic        pcnt_last;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign marker_ok = (rx_byte[7:5] == CMD_MARKER);
  assign accept    = byte_valid && marker_ok;
  assign drain     = slot_full && (iss_state == ISS_IDLE);
  assign pcnt_last = (pcnt == CW'(PULSE_CYCLES - 1));
  // Combinational from state so an async reset drops the strobe at once.
  assign control   = (iss_state == ISS_PULSE);

  always_comb begin
    iss_nxt = iss_state;
    case (iss_state)
      ISS_IDLE:  if (slot_full) iss_nxt = ISS_SETUP;
      ISS_SETUP: iss_nxt = ISS_PULSE;
      ISS_PULSE: if (pcnt_last) iss_nxt = ISS_GAP;
      ISS_GAP:   if (pcnt_last) iss_nxt = ISS_IDLE;
      default:   iss_nxt = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_state <= ISS_IDLE;
      pcnt      <= '0;
      slot_full <= 1'b0;
      slot_cmd  <= '0;
      number    <= '0;
      value     <= 1'b0;
      cmd_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      iss_state <= iss_nxt;
      if (iss_nxt != iss_state)              pcnt <= '0;
      else if (pcnt != CW'(PULSE_CYCLES))    pcnt <= pcnt + 1'b1;
      cmd_err <= byte_valid && !marker_ok;
      overrun <= accept && slot_full && !drain;
      // A byte landing in the drain cycle replaces the outgoing one.
      if (accept && (!slot_full || drain)) begin
        slot_full <= 1'b1;
        slot_cmd  <= rx_byte[VALUE_BIT:0];
      end else if (drain) begin
        slot_full <= 1'b0;
      end
      if (drain) begin
        number <= slot_cmd[IDX_MSB:0];
        value  <= slot_cmd[VALUE_BIT];
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver at CLK_HZ=3.2M, BAUD=100k (DIV=2, 32 clk/bit).
module tb_uart_cmd_receiver;

  localparam int BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] number;
  logic       control, value, cmd_err, frame_err, overrun;

  int nchk = 0, nerr = 0;
  int pulses = 0, cur_w = 0, last_w = 0, low_w = 0;
  int setup_bad = 0, gap_bad = 0;
  int cmd_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  logic       ctl_prev = 1'b0;
  logic [3:0] num_prev = '0;

  uart_cmd_receiver #(
    .CLK_HZ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16), .PULSE_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .number(number), .control(control),
    .value(value), .cmd_err(cmd_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse width, low gap, number setup before rise, and error-pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_err)   cmd_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (control && !ctl_prev) begin
        if (number !== num_prev) setup_bad++;
        if (pulses > 0 && low_w < 8) gap_bad++;
        cur_w = 0;
      end
      if (control) cur_w++;
      else         low_w++;
      if (!control && ctl_prev) begin
        pulses++;
        last_w = cur_w;
        low_w  = 1;
      end
    end
    ctl_prev = control;
    num_prev = number;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
`ifdef PARITY_CHECK_EN
    rx = (^b) ^ par_flip;
    wait_clks(BIT_CLKS);
`else
    if (par_flip) wait_clks(0);
`endif
    rx = stop_bit;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
  endtask

  initial begin
    wait_clks(3);
    @(negedge clk);
    chk("rst_number", number, 0);
    chk("rst_control", control, 0);
    chk("rst_value", value, 0);
    chk("rst_errs", {cmd_err, frame_err, overrun}, 0);
    rst_n = 1'b1;
    wait_clks(40);

    // 1: valid command, index 5, value 0
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_clks(60);
    chk("t1_pulses", pulses, 1);
    chk("t1_width", last_w, 8);
    chk("t1_number", number, 5);
    chk("t1_value", value, 0);

    // 2: index 3, value 1
    send_byte(8'hB3, 1'b1, 1'b0);
    wait_clks(60);
    chk("t2_pulses", pulses, 2);
    chk("t2_width", last_w, 8);
    chk("t2_number", number, 3);
    chk("t2_value", value, 1);
    chk("t2_errs", cmd_cnt + ferr_cnt + ovr_cnt, 0);

    // 3: bad marker
    send_byte(8'h45, 1'b1, 1'b0);
    wait_clks(60);
    chk("t3_cmd_err", cmd_cnt, 1);
    chk("t3_pulses", pulses, 2);
    chk("t3_number", number, 3);
    chk("t3_value", value, 1);

    // 4: framing error then recovery
    send_byte(8'hA1, 1'b0, 1'b0);
    wait_clks(2 * BIT_CLKS);
    send_byte(8'hA2, 1'b1, 1'b0);
    wait_clks(60);
    chk("t4_frame_err", ferr_cnt, 1);
    chk("t4_pulses", pulses, 3);
    chk("t4_number", number, 2);
    chk("t4_value", value, 0);

    // 5: 3-tick glitch ignored
    rx = 1'b0;
    wait_clks(6);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("t5_glitch_pulses", pulses, 3);
    chk("t5_glitch_errs", cmd_cnt * 10 + ferr_cnt, 11);
    send_byte(8'hA7, 1'b1, 1'b0);
    wait_clks(60);
    chk("t5_pulses", pulses, 4);
    chk("t5_number", number, 7);

    // 6: reset mid-DATA of 0xAF
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hAF >> i);
      wait_clks(BIT_CLKS);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_number", number, 0);
    chk("t6_rst_ctl_val", {control, value}, 0);
    rx = 1'b1;
    wait_clks(10);
    @(negedge clk);
    chk("t6_rst_hold", {number, control, value}, 0);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("t6_no_issue", pulses, 4);
    send_byte(8'hA4, 1'b1, 1'b0);
    wait_clks(60);
    chk("t6_pulses", pulses, 5);
    chk("t6_number", number, 4);
    chk("t6_value", value, 0);

`ifdef PARITY_CHECK_EN
    send_byte(8'hA5, 1'b1, 1'b1);
    wait_clks(60);
    chk("par_frame_err", ferr_cnt, 2);
    chk("par_pulses", pulses, 5);
`endif

    chk("setup_before_rise", setup_bad, 0);
    chk("min_low_gap", gap_bad, 0);
    chk("no_overrun", ovr_cnt, 0);
    chk("cmd_err_total", cmd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
